iob_timer_master: RTL and testbench

- Bus initiator that drives the timer's valid/ready slave port (1-bit addr: 0 = counter read, 1 = soft-reset write).
- Turns start/stop command pulses into timer transactions:
  - start → soft-reset write;
  - stop → counter read.
- Returns the elapsed cycle count, minus a fixed overhead offset, to local logic such as a profiling unit or test sequencer.
- Guards every bus transaction with a ready timeout.

---
 rtl/iob_timer_pkg.sv | 14 +
 rtl/iob_req_timeout.sv | 35 +++
 rtl/iob_timer_master.sv | 119 +++++++++++
 tb/tb_iob_timer_master.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_timer_pkg.sv
// Shared constants for the timer slave port and the iob_timer_master FSM.
// The address map is common to the timer and every initiator that drives it.
package iob_timer_pkg;

    localparam logic TIMER_ADDR_DATA  = 1'b0;
    localparam logic TIMER_ADDR_RESET = 1'b1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RST_REQ = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RESULT  = 3'd4;

endpackage

// File: rtl/iob_req_timeout.sv
// Ready-timeout watchdog for a valid/ready initiator: counts stalled cycles
// and flags expiry on the TIMEOUT-th consecutive stalled cycle.
module iob_req_timeout #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic ready,
    output logic expire
);

    localparam logic [TO_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt;
    logic            stall;

    assign stall = valid & ~ready;

    // Expiry fires while the last allowed stalled cycle is in progress, so the
    // initiator drops valid on the following cycle; TIMEOUT of 0 disables it.
    assign expire = (TIMEOUT != 0) && stall && (cnt == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (stall && !expire) begin
            cnt <= cnt + TO_W'(1);
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/iob_timer_master.sv
// Bus initiator for the timer: start issues a soft-reset write, stop reads the
// counter and returns the offset-corrected elapsed count.
module iob_timer_master
    import iob_timer_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32,
    parameter int OFFSET        = 0,
    parameter int TIMEOUT       = 16,
    parameter int TO_W          = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    output logic                     running,
    output logic                     busy,
    output logic [COUNTER_WIDTH-1:0] elapsed,
    output logic                     elapsed_valid,
    output logic                     err,
    output logic                     m_valid,
    output logic                     m_addr,
    output logic [COUNTER_WIDTH-1:0] m_wdata,
    input  logic [COUNTER_WIDTH-1:0] m_rdata,
    input  logic                     m_ready,
    output logic [2:0]               state_dbg
);

    localparam logic [COUNTER_WIDTH-1:0] OFF = COUNTER_WIDTH'(OFFSET);

    // Handshake contract: a request is presented with m_valid=1 and held
    // unchanged until a cycle where m_ready=1 is sampled; that cycle completes
    // it, and m_valid is low on the next cycle before any new request.
    logic [2:0]               state;
    logic                     hs;
    logic                     expire;
    logic                     accept_start;
    logic [COUNTER_WIDTH-1:0] adjusted;

    assign hs           = m_valid & m_ready;
    assign accept_start = start && (state == ST_IDLE || state == ST_RUN);
    assign adjusted     = (m_rdata >= OFF) ? (m_rdata - OFF) : '0;
    assign state_dbg    = state;

    iob_req_timeout #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .valid  (m_valid),
        .ready  (m_ready),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            running       <= 1'b0;
            busy          <= 1'b0;
            elapsed       <= '0;
            elapsed_valid <= 1'b0;
            err           <= 1'b0;
            m_valid       <= 1'b0;
            m_addr        <= 1'b0;
            m_wdata       <= '0;
        end else begin
            elapsed_valid <= 1'b0;
            // start has priority over stop in both IDLE and RUN
            if (accept_start) begin
                state   <= ST_RST_REQ;
                m_valid <= 1'b1;
                m_addr  <= TIMER_ADDR_RESET;
                m_wdata <= COUNTER_WIDTH'(1);
                busy    <= 1'b1;
                running <= 1'b0;
                err     <= 1'b0;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (stop) begin
                            state   <= ST_RD_REQ;
                            m_valid <= 1'b1;
                            m_addr  <= TIMER_ADDR_DATA;
                            m_wdata <= '0;
                            busy    <= 1'b1;
                            running <= 1'b0;
                        end
                    end
                    ST_RST_REQ, ST_RD_REQ: begin
                        if (hs) begin
                            m_valid <= 1'b0;
                            m_addr  <= 1'b0;
                            m_wdata <= '0;
                            busy    <= 1'b0;
                            if (state == ST_RST_REQ) begin
                                state   <= ST_RUN;
                                running <= 1'b1;
                            end else begin
                                state         <= ST_RESULT;
                                elapsed       <= adjusted;
                                elapsed_valid <= 1'b1;
                            end
                        end else if (expire) begin
                            state   <= ST_IDLE;
                            m_valid <= 1'b0;
                            m_addr  <= 1'b0;
                            m_wdata <= '0;
                            busy    <= 1'b0;
                            err     <= 1'b1;
                        end
                    end
                    ST_RESULT: state <= ST_IDLE;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iob_timer_master.sv
// Directed bench for iob_timer_master: two instances (OFFSET 0 and 3), each
// driven against a small timer slave model with a configurable ready delay.
module tb_iob_timer_master;
    import iob_timer_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance 0: OFFSET 0 ----------------
    logic         start0 = 1'b0, stop0 = 1'b0;
    logic         running0, busy0, ev0, err0, m_valid0, m_addr0;
    logic [W-1:0] elapsed0, m_wdata0, m_rdata0;
    logic         m_ready0 = 1'b0;
    logic [2:0]   st0;

    iob_timer_master #(.COUNTER_WIDTH(W), .OFFSET(0), .TIMEOUT(16), .TO_W(5)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .stop(stop0),
        .running(running0), .busy(busy0), .elapsed(elapsed0), .elapsed_valid(ev0),
        .err(err0), .m_valid(m_valid0), .m_addr(m_addr0), .m_wdata(m_wdata0),
        .m_rdata(m_rdata0), .m_ready(m_ready0), .state_dbg(st0)
    );

    // ---------------- instance 1: OFFSET 3 ----------------
    logic         start1 = 1'b0, stop1 = 1'b0;
    logic         running1, busy1, ev1, err1, m_valid1, m_addr1;
    logic [W-1:0] elapsed1, m_wdata1, m_rdata1;
    logic         m_ready1 = 1'b0;
    logic [2:0]   st1;

    iob_timer_master #(.COUNTER_WIDTH(W), .OFFSET(3), .TIMEOUT(16), .TO_W(5)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .stop(stop1),
        .running(running1), .busy(busy1), .elapsed(elapsed1), .elapsed_valid(ev1),
        .err(err1), .m_valid(m_valid1), .m_addr(m_addr1), .m_wdata(m_wdata1),
        .m_rdata(m_rdata1), .m_ready(m_ready1), .state_dbg(st1)
    );

    // ---------------- timer slave models ----------------
    int           extra_wait = 0;
    logic         never_ready = 1'b0;
    int           wait0 = 0, wait1 = 0;
    logic [W-1:0] tcnt0 = '0, tcnt1 = '0;
    logic         force1_en = 1'b0;
    logic [W-1:0] force1_val = '0;

    assign m_rdata0 = tcnt0;
    assign m_rdata1 = force1_en ? force1_val : tcnt1;

    always @(posedge clk) begin
        wait0    <= (m_valid0 && !m_ready0) ? wait0 + 1 : 0;
        m_ready0 <= m_valid0 && !m_ready0 && !never_ready && (wait0 >= extra_wait);
        tcnt0    <= (m_valid0 && m_ready0 && m_addr0) ? '0 : tcnt0 + 1;
        wait1    <= (m_valid1 && !m_ready1) ? wait1 + 1 : 0;
        m_ready1 <= m_valid1 && !m_ready1;
        tcnt1    <= (m_valid1 && m_ready1 && m_addr1) ? '0 : tcnt1 + 1;
    end

    // ---------------- bus monitor ----------------
    int           wr_cnt0 = 0, rd_cnt0 = 0, ev_cnt0 = 0, ev_cnt1 = 0;
    int           wr_cyc0 = 0, rd_cyc0 = 0, ev_cyc0 = 0, ev_cyc1 = 0;
    int           cur_run0 = 0, last_run0 = 0;
    logic [W-1:0] wr_data0 = '0, rd_data0 = '0;

    always @(negedge clk) begin
        if (m_valid0 && m_ready0) begin
            if (m_addr0) begin
                wr_cnt0  <= wr_cnt0 + 1;
                wr_cyc0  <= cyc;
                wr_data0 <= m_wdata0;
            end else begin
                rd_cnt0  <= rd_cnt0 + 1;
                rd_cyc0  <= cyc;
                rd_data0 <= m_rdata0;
            end
        end
        if (ev0) begin
            ev_cnt0 <= ev_cnt0 + 1;
            ev_cyc0 <= cyc;
        end
        if (ev1) begin
            ev_cnt1 <= ev_cnt1 + 1;
            ev_cyc1 <= cyc;
        end
        if (m_valid0) begin
            cur_run0 <= cur_run0 + 1;
        end else if (cur_run0 != 0) begin
            last_run0 <= cur_run0;
            cur_run0  <= 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic pulse0(input logic s, input logic p);
        start0 = s;
        stop0  = p;
        tick();
        start0 = 1'b0;
        stop0  = 1'b0;
    endtask

    task automatic pulse1(input logic s, input logic p);
        start1 = s;
        stop1  = p;
        tick();
        start1 = 1'b0;
        stop1  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (m_valid0 !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %0d exp 0", m_valid0); end
        checks++; if (m_wdata0 !== '0 || m_addr0 !== 1'b0) begin failures++; $display("FAIL reset_bus: got addr=%0d wdata=%0d exp 0/0", m_addr0, m_wdata0); end
        checks++; if (busy0 !== 1'b0 || running0 !== 1'b0 || err0 !== 1'b0) begin failures++; $display("FAIL reset_flags: got busy=%0d run=%0d err=%0d exp 0", busy0, running0, err0); end
        checks++; if (elapsed0 !== '0 || ev0 !== 1'b0) begin failures++; $display("FAIL reset_elapsed: got %0d/%0d exp 0/0", elapsed0, ev0); end
        checks++; if (st0 !== ST_IDLE || st1 !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d/%0d exp %0d", st0, st1, ST_IDLE); end
    endtask

    task automatic test_basic();
        int base, wr0, rd0, e0;
        base = cyc; wr0 = wr_cnt0; rd0 = rd_cnt0; e0 = ev_cnt0;
        wait_to(base + 10);
        pulse0(1'b1, 1'b0);
        checks++; if (m_valid0 !== 1'b1 || m_addr0 !== 1'b1 || m_wdata0 !== 32'd1) begin failures++; $display("FAIL basic_wr_req: got v=%0d a=%0d d=%0d exp 1/1/1", m_valid0, m_addr0, m_wdata0); end
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL basic_busy: got %0d exp 1", busy0); end
        wait_to(base + 13);
        checks++; if (running0 !== 1'b1 || m_valid0 !== 1'b0 || m_wdata0 !== '0) begin failures++; $display("FAIL basic_run: got run=%0d v=%0d d=%0d exp 1/0/0", running0, m_valid0, m_wdata0); end
        wait_to(base + 60);
        pulse0(1'b0, 1'b1);
        checks++; if (m_valid0 !== 1'b1 || m_addr0 !== 1'b0 || running0 !== 1'b0) begin failures++; $display("FAIL basic_rd_req: got v=%0d a=%0d run=%0d exp 1/0/0", m_valid0, m_addr0, running0); end
        wait_to(base + 64);
        checks++; if (wr_cyc0 !== base + 12 || wr_cnt0 - wr0 !== 1 || wr_data0 !== 32'd1) begin failures++; $display("FAIL basic_wr_hs: got cyc=%0d n=%0d d=%0d exp cyc=%0d n=1 d=1", wr_cyc0 - base, wr_cnt0 - wr0, wr_data0, 12); end
        checks++; if (rd_cyc0 !== base + 62 || rd_cnt0 - rd0 !== 1) begin failures++; $display("FAIL basic_rd_hs: got cyc=%0d n=%0d exp cyc=62 n=1", rd_cyc0 - base, rd_cnt0 - rd0); end
        checks++; if (elapsed0 !== 32'd49 || rd_data0 !== 32'd49) begin failures++; $display("FAIL basic_elapsed: got %0d (raw %0d) exp 49", elapsed0, rd_data0); end
        checks++; if (ev_cnt0 - e0 !== 1 || ev_cyc0 !== base + 63) begin failures++; $display("FAIL basic_ev: got n=%0d cyc=%0d exp n=1 cyc=63", ev_cnt0 - e0, ev_cyc0 - base); end
        checks++; if (st0 !== ST_IDLE || ev0 !== 1'b0) begin failures++; $display("FAIL basic_end_state: got st=%0d ev=%0d exp %0d/0", st0, ev0, ST_IDLE); end
    endtask

    task automatic test_offset();
        int base, e1;
        base = cyc; e1 = ev_cnt1;
        wait_to(base + 10);
        pulse1(1'b1, 1'b0);
        wait_to(base + 60);
        pulse1(1'b0, 1'b1);
        wait_to(base + 64);
        checks++; if (elapsed1 !== 32'd46) begin failures++; $display("FAIL offset_elapsed: got %0d exp 46", elapsed1); end
        checks++; if (ev_cnt1 - e1 !== 1 || ev_cyc1 !== base + 63) begin failures++; $display("FAIL offset_ev: got n=%0d cyc=%0d exp n=1 cyc=63", ev_cnt1 - e1, ev_cyc1 - base); end
        force1_en = 1'b1; force1_val = 32'd2;
        base = cyc;
        wait_to(base + 2);
        pulse1(1'b1, 1'b0);
        wait_to(base + 8);
        checks++; if (elapsed1 !== 32'd46 || running1 !== 1'b1) begin failures++; $display("FAIL offset_held: got %0d run=%0d exp 46/1", elapsed1, running1); end
        wait_to(base + 12);
        pulse1(1'b0, 1'b1);
        wait_to(base + 16);
        checks++; if (elapsed1 !== '0 || ev_cnt1 - e1 !== 2) begin failures++; $display("FAIL offset_saturate: got %0d n=%0d exp 0 n=2", elapsed1, ev_cnt1 - e1); end
        force1_en = 1'b0;
    endtask

    task automatic test_stall();
        int base, wr0;
        base = cyc; wr0 = wr_cnt0;
        extra_wait = 4;
        wait_to(base + 2);
        pulse0(1'b1, 1'b0);
        wait_to(base + 12);
        checks++; if (last_run0 !== 6) begin failures++; $display("FAIL stall_valid_len: got %0d exp 6", last_run0); end
        checks++; if (wr_cnt0 - wr0 !== 1 || wr_cyc0 !== base + 8) begin failures++; $display("FAIL stall_hs: got n=%0d cyc=%0d exp n=1 cyc=8", wr_cnt0 - wr0, wr_cyc0 - base); end
        checks++; if (err0 !== 1'b0 || running0 !== 1'b1) begin failures++; $display("FAIL stall_flags: got err=%0d run=%0d exp 0/1", err0, running0); end
        extra_wait = 0;
        wait_to(base + 14);
        pulse0(1'b0, 1'b1);
        wait_to(base + 20);
        checks++; if (elapsed0 !== 32'd7) begin failures++; $display("FAIL stall_elapsed: got %0d exp 7", elapsed0); end
    endtask

    task automatic test_timeout();
        int base, wr0, e0;
        base = cyc; wr0 = wr_cnt0; e0 = ev_cnt0;
        never_ready = 1'b1;
        wait_to(base + 2);
        pulse0(1'b1, 1'b0);
        wait_to(base + 18);
        checks++; if (m_valid0 !== 1'b1 || err0 !== 1'b0) begin failures++; $display("FAIL timeout_last_valid: got v=%0d err=%0d exp 1/0", m_valid0, err0); end
        wait_to(base + 22);
        checks++; if (last_run0 !== 16) begin failures++; $display("FAIL timeout_valid_len: got %0d exp 16", last_run0); end
        checks++; if (err0 !== 1'b1 || st0 !== ST_IDLE || busy0 !== 1'b0) begin failures++; $display("FAIL timeout_abort: got err=%0d st=%0d busy=%0d exp 1/%0d/0", err0, st0, busy0, ST_IDLE); end
        checks++; if (wr_cnt0 - wr0 !== 0 || ev_cnt0 - e0 !== 0) begin failures++; $display("FAIL timeout_no_hs: got wr=%0d ev=%0d exp 0/0", wr_cnt0 - wr0, ev_cnt0 - e0); end
        never_ready = 1'b0;
        wait_to(base + 24);
        pulse0(1'b1, 1'b0);
        checks++; if (err0 !== 1'b0 || m_valid0 !== 1'b1) begin failures++; $display("FAIL timeout_err_clear: got err=%0d v=%0d exp 0/1", err0, m_valid0); end
        wait_to(base + 30);
        checks++; if (running0 !== 1'b1 || wr_cnt0 - wr0 !== 1) begin failures++; $display("FAIL timeout_recover: got run=%0d wr=%0d exp 1/1", running0, wr_cnt0 - wr0); end
    endtask

    task automatic test_cmds();
        int base, wr0, rd0, e0;
        do_reset();
        base = cyc; wr0 = wr_cnt0; rd0 = rd_cnt0; e0 = ev_cnt0;
        wait_to(base + 2);
        pulse0(1'b0, 1'b1);
        wait_to(base + 5);
        checks++; if (st0 !== ST_IDLE || m_valid0 !== 1'b0 || rd_cnt0 - rd0 !== 0) begin failures++; $display("FAIL cmds_stop_idle: got st=%0d v=%0d rd=%0d exp %0d/0/0", st0, m_valid0, rd_cnt0 - rd0, ST_IDLE); end
        wait_to(base + 6);
        pulse0(1'b1, 1'b1);
        checks++; if (m_valid0 !== 1'b1 || m_addr0 !== 1'b1) begin failures++; $display("FAIL cmds_both_idle: got v=%0d a=%0d exp 1/1", m_valid0, m_addr0); end
        wait_to(base + 12);
        pulse0(1'b1, 1'b0);
        checks++; if (m_valid0 !== 1'b1 || m_addr0 !== 1'b1 || running0 !== 1'b0) begin failures++; $display("FAIL cmds_restart: got v=%0d a=%0d run=%0d exp 1/1/0", m_valid0, m_addr0, running0); end
        wait_to(base + 20);
        pulse0(1'b1, 1'b1);
        checks++; if (m_addr0 !== 1'b1) begin failures++; $display("FAIL cmds_both_run: got a=%0d exp 1", m_addr0); end
        wait_to(base + 26);
        checks++; if (wr_cnt0 - wr0 !== 3 || rd_cnt0 - rd0 !== 0 || ev_cnt0 - e0 !== 0) begin failures++; $display("FAIL cmds_counts: got wr=%0d rd=%0d ev=%0d exp 3/0/0", wr_cnt0 - wr0, rd_cnt0 - rd0, ev_cnt0 - e0); end
        checks++; if (tcnt0 !== 32'd3 || running0 !== 1'b1) begin failures++; $display("FAIL cmds_timer_rereset: got cnt=%0d run=%0d exp 3/1", tcnt0, running0); end
    endtask

    task automatic test_async_reset();
        int base, e0;
        do_reset();
        base = cyc; e0 = ev_cnt0;
        wait_to(base + 2);
        pulse0(1'b1, 1'b0);
        wait_to(base + 12);
        pulse0(1'b0, 1'b1);
        wait_to(base + 17);
        checks++; if (elapsed0 !== 32'd9 || ev_cnt0 - e0 !== 1) begin failures++; $display("FAIL async_pre_result: got %0d n=%0d exp 9 n=1", elapsed0, ev_cnt0 - e0); end
        wait_to(base + 18);
        pulse0(1'b1, 1'b0);
        wait_to(base + 28);
        pulse0(1'b0, 1'b1);
        checks++; if (m_valid0 !== 1'b1 || st0 !== ST_RD_REQ) begin failures++; $display("FAIL async_in_rd: got v=%0d st=%0d exp 1/%0d", m_valid0, st0, ST_RD_REQ); end
        rst = 1'b1;
        #1;
        checks++; if (m_valid0 !== 1'b0 || st0 !== ST_IDLE || busy0 !== 1'b0) begin failures++; $display("FAIL async_drop: got v=%0d st=%0d busy=%0d exp 0/%0d/0", m_valid0, st0, busy0, ST_IDLE); end
        checks++; if (elapsed0 !== '0 || m_addr0 !== 1'b0 || running0 !== 1'b0) begin failures++; $display("FAIL async_clear: got el=%0d a=%0d run=%0d exp 0/0/0", elapsed0, m_addr0, running0); end
        tick();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        checks++; if (ev_cnt0 - e0 !== 1 || m_valid0 !== 1'b0) begin failures++; $display("FAIL async_no_result: got n=%0d v=%0d exp 1/0", ev_cnt0 - e0, m_valid0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_offset();
        test_stall();
        test_timeout();
        test_cmds();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
